// File: rtl/cpu_lab_pkg.sv
// cpu_lab_pkg: shared FSM encoding, header byte and default bit period for the RAM dump transmitter.
package cpu_lab_pkg;
    typedef enum logic [2:0] {IDLE, RD, RWAIT, SEND, NEXT, FIN} dump_state_t;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int CLK_DIV_DEF = 868;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready also rises in the last stop-bit cycle so back-to-back loads leave no idle gap.
module uart_tx_byte import cpu_lab_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    sh;
    logic          bit_end;
    assign bit_end = cnt == CW'(CLK_DIV - 1);
    assign ready   = !active || (bit_end && bit_idx == 4'd9);
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '1;
            txd     <= 1'b1;
        end else if (load && ready) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= {1'b1, data};
            txd     <= 1'b0;
        end else if (active) begin
            if (!bit_end) begin
                cnt <= cnt + CW'(1);
            end else if (bit_idx == 4'd9) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                // the stop bit is the 1 parked above the data byte
                cnt     <= '0;
                bit_idx <= bit_idx + 4'd1;
                txd     <= sh[0];
                sh      <= {1'b1, sh[8:1]};
            end
        end
    end
endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: reads a word range from the data memory debug port and streams it LSB-first over UART 8N1.
// Define RAM_DUMP_HDR_EN to prefix non-empty dumps with 0xA5 and the 16-bit start address.
module ram_dump_tx import cpu_lab_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_first,
    input  logic [ADDR_W-1:0] addr_last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    dump_state_t       state;
    logic [ADDR_W-1:0] last_q;
    logic [31:0]       word_q;
    logic [2:0]        nsent;
    logic              ready;
    logic              load;
    logic [7:0]        tx_byte;
    logic              sent_all;
`ifdef RAM_DUMP_HDR_EN
    logic [ADDR_W-1:0] first_q;
    logic [1:0]        hdr_cnt;
    logic [15:0]       hdr_addr;
    assign hdr_addr = 16'(first_q);
    assign tx_byte  = hdr_cnt == 2'd3 ? HDR_BYTE :
                      hdr_cnt == 2'd2 ? hdr_addr[7:0] :
                      hdr_cnt == 2'd1 ? hdr_addr[15:8] : word_q[7:0];
    assign sent_all = nsent == 3'd4 && hdr_cnt == 2'd0;
`else
    assign tx_byte  = word_q[7:0];
    assign sent_all = nsent == 3'd4;
`endif
    assign load = state == SEND && ready && !sent_all;

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk  (clk),
        .RST_n(RST_n),
        .load (load),
        .data (tx_byte),
        .ready(ready),
        .txd  (txd)
    );

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            last_q  <= '0;
            word_q  <= '0;
            nsent   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef RAM_DUMP_HDR_EN
            first_q <= '0;
            hdr_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    rd_addr <= addr_first;
                    last_q  <= addr_last;
`ifdef RAM_DUMP_HDR_EN
                    first_q <= addr_first;
                    hdr_cnt <= addr_last < addr_first ? 2'd0 : 2'd3;
`endif
                    // an empty range goes straight to the end-of-range check
                    state   <= addr_last < addr_first ? NEXT : RD;
                end
                RD:    state <= RWAIT;
                RWAIT: begin
                    word_q <= rd_data;
                    state  <= SEND;
                end
                SEND: if (ready) begin
                    if (sent_all) begin
                        nsent <= '0;
                        state <= NEXT;
                    end else begin
`ifdef RAM_DUMP_HDR_EN
                        if (hdr_cnt != 2'd0) begin
                            hdr_cnt <= hdr_cnt - 2'd1;
                        end else begin
                            nsent  <= nsent + 3'd1;
                            word_q <= word_q >> 8;
                        end
`else
                        nsent  <= nsent + 3'd1;
                        word_q <= word_q >> 8;
`endif
                    end
                end
                NEXT: if (rd_addr < last_q) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    state   <= RD;
                end else begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: directed and randomized dumps checked against a byte-stream model and a UART receiver.
module tb_ram_dump_tx;
    localparam int DIV = 4;
`ifdef RAM_DUMP_HDR_EN
    localparam int HDR = 3;
`else
    localparam int HDR = 0;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] addr_first, addr_last, rd_addr;
    logic [31:0] rd_data;
    logic        txd, busy, done;
    logic [31:0] mem [0:4095];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [11:0] adr_q[$];
    int cyc_cnt = 0, stop_err = 0, n_vec = 0, n_err = 0;
    int busy_cyc, done_cyc, ndone;

    ram_dump_tx #(.CLK_DIV(DIV), .ADDR_W(12)) dut (
        .clk(clk), .RST_n(rst_n), .start(start), .addr_first(addr_first), .addr_last(addr_last),
        .rd_addr(rd_addr), .rd_data(rd_data), .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(posedge clk) rd_data <= mem[rd_addr];

    // receiver samples each bit in its second clock
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                start_q.push_back(cyc_cnt);
                repeat (DIV / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                if (txd !== 1'b1) stop_err++;
                got_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_exp(input int f, input int l);
        exp_q.delete();
        if (l < f) return;
`ifdef RAM_DUMP_HDR_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(f));
        exp_q.push_back(8'(f >> 8));
`endif
        for (int a = f; a <= l; a++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(mem[a] >> (8 * k)));
    endfunction

    task automatic run_dump(input int f, input int l, input bit disturb);
        int tail = -1;
        int budget = (l >= f ? l - f + 1 : 1) * (40 * DIV + 20) + 100;
        got_q.delete(); start_q.delete(); adr_q.delete();
        stop_err = 0; busy_cyc = 0; done_cyc = -1; ndone = 0;
        @(negedge clk);
        addr_first = 12'(f); addr_last = 12'(l); start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && c == 50) begin
                addr_first = 12'(f + 7); addr_last = 12'(l + 9); start = 1'b1;
            end
            if (busy === 1'b1) begin
                busy_cyc++;
                if (adr_q.size() == 0 || adr_q[$] != rd_addr) adr_q.push_back(rd_addr);
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (ndone > 0 && tail < 0) tail = 20;
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
    endtask

    task automatic check_dump(input string tag, input int f, input int l);
        int bad = 0;
        int words = l - f + 1;
        build_exp(f, l);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_busy_span"}, busy_cyc, done_cyc - 1);
        chk({tag, "_busy_len"}, busy_cyc >= words * 40 * DIV && busy_cyc <= words * (40 * DIV + 8) + 4, 1);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_stop_bits"}, stop_err, 0);
        chk({tag, "_naddr"}, adr_q.size(), words);
        for (int i = 0; i < adr_q.size() && i < words; i++)
            chk($sformatf("%s_addr%0d", tag, i), adr_q[i], f + i);
        for (int k = 0; k + 1 < start_q.size(); k++)
            if ((k < HDR ? 0 : (k - HDR) / 4) == (k + 1 < HDR ? 0 : (k + 1 - HDR) / 4) &&
                start_q[k + 1] - start_q[k] != 10 * DIV) bad++;
        chk({tag, "_gapless"}, bad, 0);
    endtask

    initial begin
        int f, l, lows, highs;
        rst_n = 1'b0; start = 1'b0; addr_first = '0; addr_last = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;

        mem[3] = 32'h12345678;
        run_dump(3, 3, 0);
        check_dump("single", 3, 3);

        for (int n = 0; n < 3; n++) mem[n] = n + 32'h100;
        run_dump(0, 2, 0);
        check_dump("range012", 0, 2);

        run_dump(5, 4, 0);
        chk("empty_done_cyc", done_cyc, 2);
        chk("empty_done_count", ndone, 1);
        chk("empty_busy", busy_cyc <= 2, 1);
        chk("empty_no_tx", start_q.size(), 0);

        f = $urandom_range(100, 200); l = f + 1;
        run_dump(f, l, 1);
        check_dump("disturbed", f, l);

        run_dump(4094, 4095, 0);
        check_dump("top_edge", 4094, 4095);

        for (int t = 0; t < 3; t++) begin
            f = $urandom_range(0, 4000); l = f + $urandom_range(0, 2);
            run_dump(f, l, 0);
            check_dump($sformatf("rand%0d", t), f, l);
        end

        @(negedge clk);
        addr_first = 12'd10; addr_last = 12'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && txd !== 1'b0; i++) @(negedge clk);
        chk("abort_frame_began", txd, 0);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rd_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0; highs = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
            if (busy !== 1'b0) highs++;
        end
        chk("abort_quiet_txd", lows, 0);
        chk("abort_quiet_busy", highs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_dump_tx.md
RAM_DUMP_TX -- requirements
Module: ram_dump_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, meaning clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning data-memory debug read-port address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a dump.
REQ-006 SHALL have port addr_first, input, ADDR_W bits: first word address, sampled on accepted start.
REQ-007 SHALL have port addr_last, input, ADDR_W bits: last word address, inclusive, sampled on accepted start.
REQ-008 SHALL have port rd_addr, output, ADDR_W bits: address driven to the data-memory extra read port.
REQ-009 SHALL have port rd_data, input, 32 bits: read-port data, valid one cycle after rd_addr changes.
REQ-010 SHALL have port txd, output, 1 bit: UART 8N1 serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high from accepted start until the done pulse.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the dump completes.

Function
REQ-013 SHALL use FSM states IDLE, RD, RWAIT, SEND, NEXT, FIN.
- IDLE->RD on start; RD->RWAIT after one cycle; RWAIT->SEND.
- SEND->NEXT after 4 bytes; NEXT->RD if another address remains, else FIN.
- FIN->IDLE after one cycle.
REQ-014 SHALL latch rd_data into a 32-bit shift buffer in RWAIT, exactly one cycle after rd_addr was set in RD.
REQ-015 SHALL send each word as 4 bytes, least-significant byte first, with no idle gap between bytes of the same word.
REQ-016 SHALL frame each byte as start bit 0, data bits LSB first, stop bit 1, with every bit lasting exactly CLK_DIV cycles.
REQ-017 SHALL increment rd_addr by 1 per word, stop after addr_last, and never wrap past all-ones.
REQ-018 SHALL, when addr_last < addr_first on start, transmit nothing and pulse done 2 cycles after start.
REQ-019 SHALL ignore start while busy is high; the latched range is unaffected.
REQ-020 SHALL pulse done in FIN for exactly one cycle; busy falls in the same cycle as the done pulse.
REQ-021 SHALL treat addr_first == addr_last as a single-word dump.

Reset
REQ-022 SHALL, on RST_n low, immediately set state IDLE, txd=1, busy=0, done=0, rd_addr=0, and clear the bit and byte counters.
REQ-023 SHALL abort any in-progress frame when reset is asserted mid-frame; txd returns high without completing the stop bit, and nothing resumes after release.

Configuration
REQ-024 SHALL, with macro RAM_DUMP_HDR_EN defined, precede the first word with header byte 0xA5, then addr_first as 2 bytes, LSB first, zero-extended.
REQ-025 SHALL, without RAM_DUMP_HDR_EN, transmit only word data; the empty-range case (REQ-018) sends no header in either build.

Structure
REQ-026 SHALL take the FSM state encodings, header byte 0xA5, and default CLK_DIV from the shared package cpu_lab_pkg.
REQ-027 SHALL place the 8N1 serializer in one sub-module, uart_tx_byte, with handshake load/ready.
- ready is high when idle.
- load is accepted only when ready is high.
- ready falls the cycle after load.

Verification
REQ-028 SHALL verify: CLK_DIV=4, addr 3..3, rd_data=0x12345678 -> bytes 78,56,34,12 on txd; busy for 4*10*4 + overhead cycles; one done pulse.
REQ-029 SHALL verify: range 0..2 with memory word n = n+0x100 -> 12 bytes 00,01,00,00,01,01,00,00,02,01,00,00; rd_addr sequence 0,1,2.
REQ-030 SHALL verify: addr_first=5, addr_last=4 -> txd stays 1, done exactly 2 cycles after start, busy never exceeds 2 cycles.
REQ-031 SHALL verify: start pulsed again mid-dump with a different range -> output identical to the undisturbed dump.
REQ-032 SHALL verify: RST_n low during the 3rd data bit -> txd=1 and busy=0 immediately; after release, txd stays 1 with no transmission.
REQ-033 SHALL verify: with RAM_DUMP_HDR_EN defined, range 0x0AB..0x0AB -> A5, AB, 00 followed by the 4 data bytes.
